// File: rtl/phase_track_ctrl.sv
// Phase-lock sequencer: averages wrapped zero-crossing errors over a window,
// steers the DA phase offset, and tracks lock and loss-of-signal status.
`timescale 1ns/1ps
module phase_track_ctrl #(
  parameter int TARGET_DEG  = 90,
  parameter int AVG_LOG2    = 3,
  parameter int GAIN_SHIFT  = 1,
  parameter int SETTLE_CYC  = 256,
  parameter int LOCK_TOL    = 4,
  parameter int UNLOCK_TOL  = 12,
  parameter int LOCK_CNT    = 3,
  parameter int TIMEOUT_CYC = 600000
) (
  input  logic               clk_60m,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               meas_strobe,
  input  logic [8:0]         meas_phase,
  output logic [15:0]        phase_offset,
  output logic               offset_update,
  output logic signed [9:0]  mean_err,
  output logic               locked,
  output logic               lost,
  output logic [2:0]         state
);

  localparam int DATA_W = 9;
  localparam int ACC_W  = DATA_W + AVG_LOG2 + 1;
  localparam int CNT_W  = AVG_LOG2 + 1;
  localparam int SET_W  = $clog2(SETTLE_CYC + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam int RUN_W  = $clog2(LOCK_CNT + 1);

  localparam logic signed [10:0] TGT          = 11'(TARGET_DEG);
  localparam logic [CNT_W-1:0]   N_LAST       = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [SET_W-1:0]   SET_LAST     = SET_W'(SETTLE_CYC - 1);
  localparam logic [TO_W-1:0]    TO_LAST      = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [RUN_W-1:0]   LOCK_CNT_V   = RUN_W'(LOCK_CNT);
  localparam logic [9:0]         LOCK_TOL_V   = 10'(LOCK_TOL);
  localparam logic [9:0]         UNLOCK_TOL_V = 10'(UNLOCK_TOL);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACQUIRE = 3'd1,
    S_ADJUST  = 3'd2,
    S_SETTLE  = 3'd3,
    S_LOST    = 3'd4
  } state_t;

  state_t cur_st, nxt_st;

  logic signed [ACC_W-1:0] sum_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [SET_W-1:0]        settle_q;
  logic [TO_W-1:0]         to_q;
  logic [RUN_W-1:0]        run_q;

  logic signed [10:0]      samp_err;
  logic signed [9:0]       mean_c;
  logic signed [17:0]      corr_c;
  logic [9:0]              mean_abs;
  logic [RUN_W-1:0]        run_inc;
  logic                    to_hit;

  // Wrap a raw angle difference into -180..179; 360 aliases to 0.
  function automatic logic signed [10:0] wrap_err(input logic [8:0] ph);
    logic [8:0]         p;
    logic signed [10:0] e;
    p = (ph == 9'd360) ? 9'd0 : ph;
    e = $signed({2'b00, p}) - TGT;
    if (e >= 11'sd180)
      e = e - 11'sd360;
    else if (e < -11'sd180)
      e = e + 11'sd360;
    return e;
  endfunction

  function automatic logic [9:0] abs10(input logic signed [9:0] v);
    return v[9] ? 10'(-v) : 10'(v);
  endfunction

  function automatic logic [RUN_W-1:0] sat_inc(input logic [RUN_W-1:0] v);
    return (v < LOCK_CNT_V) ? v + 1'b1 : v;
  endfunction

  assign samp_err = wrap_err(meas_phase);
  assign mean_c   = 10'(sum_q >>> AVG_LOG2);
  assign corr_c   = (18'(mean_c) * 18'sd182) >>> GAIN_SHIFT;
  assign mean_abs = abs10(mean_c);
  assign run_inc  = sat_inc(run_q);
  assign to_hit   = ((cur_st == S_ACQUIRE) || (cur_st == S_SETTLE)) &&
                    !meas_strobe && (to_q == TO_LAST);
  assign state    = cur_st;

  always_ff @(posedge clk_60m or negedge rst_n) begin
    if (!rst_n)
      cur_st <= S_IDLE;
    else
      cur_st <= nxt_st;
  end

  always_comb begin
    nxt_st = cur_st;
    if (!enable) begin
      nxt_st = S_IDLE;
    end else begin
      case (cur_st)
        S_IDLE:    nxt_st = S_ACQUIRE;
        S_ACQUIRE: begin
          if (meas_strobe && (cnt_q == N_LAST))
            nxt_st = S_ADJUST;
          else if (to_hit)
            nxt_st = S_LOST;
        end
        S_ADJUST:  nxt_st = S_SETTLE;
        S_SETTLE: begin
          if (to_hit)
            nxt_st = S_LOST;
          else if (settle_q == SET_LAST)
            nxt_st = S_ACQUIRE;
        end
        S_LOST: begin
          if (meas_strobe)
            nxt_st = S_ACQUIRE;
        end
        default:   nxt_st = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_60m or negedge rst_n) begin
    if (!rst_n) begin
      sum_q         <= '0;
      cnt_q         <= '0;
      settle_q      <= '0;
      to_q          <= '0;
      run_q         <= '0;
      phase_offset  <= '0;
      offset_update <= 1'b0;
      mean_err      <= '0;
      locked        <= 1'b0;
      lost          <= 1'b0;
    end else begin
      offset_update <= 1'b0;
      if (!enable) begin
        sum_q    <= '0;
        cnt_q    <= '0;
        settle_q <= '0;
        to_q     <= '0;
        run_q    <= '0;
        locked   <= 1'b0;
        lost     <= 1'b0;
      end else begin
        case (cur_st)
          S_IDLE: begin
            sum_q <= '0;
            cnt_q <= '0;
            run_q <= '0;
            to_q  <= '0;
          end
          S_ACQUIRE: begin
            if (meas_strobe) begin
              sum_q <= sum_q + ACC_W'(samp_err);
              cnt_q <= cnt_q + 1'b1;
              to_q  <= '0;
            end else if (to_hit) begin
              to_q   <= '0;
              lost   <= 1'b1;
              locked <= 1'b0;
              run_q  <= '0;
            end else begin
              to_q <= to_q + 1'b1;
            end
          end
          // Window complete: publish mean, steer offset, update lock status.
          S_ADJUST: begin
            mean_err      <= mean_c;
            phase_offset  <= phase_offset - 16'(corr_c);
            offset_update <= (corr_c != 18'sd0);
            settle_q      <= '0;
            if (meas_strobe)
              to_q <= '0;
            if (mean_abs <= LOCK_TOL_V) begin
              run_q <= run_inc;
              if (run_inc == LOCK_CNT_V)
                locked <= 1'b1;
            end else begin
              run_q <= '0;
              if (locked && (mean_abs > UNLOCK_TOL_V))
                locked <= 1'b0;
            end
          end
          S_SETTLE: begin
            if (meas_strobe) begin
              to_q <= '0;
            end else if (to_hit) begin
              to_q   <= '0;
              lost   <= 1'b1;
              locked <= 1'b0;
              run_q  <= '0;
            end else begin
              to_q <= to_q + 1'b1;
            end
            if (settle_q == SET_LAST) begin
              settle_q <= '0;
              sum_q    <= '0;
              cnt_q    <= '0;
            end else begin
              settle_q <= settle_q + 1'b1;
            end
          end
          S_LOST: begin
            to_q <= '0;
            if (meas_strobe) begin
              lost  <= 1'b0;
              sum_q <= '0;
              cnt_q <= '0;
            end
          end
          default: begin
            sum_q <= '0;
            cnt_q <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_phase_track_ctrl.sv
// Scoreboard bench for phase_track_ctrl: two instances (target 90 and 10)
// share one stimulus stream; a window-level model predicts each ADJUST result.
`timescale 1ns/1ps
module tb_phase_track_ctrl;

  localparam int AVG_LOG2    = 2;
  localparam int GAIN_SHIFT  = 1;
  localparam int SETTLE_CYC  = 16;
  localparam int TIMEOUT_CYC = 1000;

  logic clk_60m = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic meas_strobe = 1'b0;
  logic [8:0] meas_phase = '0;

  logic [15:0] po0, po1;
  logic ou0, ou1, lk0, lk1, ls0, ls1;
  logic signed [9:0] me0, me1;
  logic [2:0] st0, st1;

  always #8 clk_60m = ~clk_60m;

  phase_track_ctrl #(
    .TARGET_DEG(90), .AVG_LOG2(AVG_LOG2), .GAIN_SHIFT(GAIN_SHIFT),
    .SETTLE_CYC(SETTLE_CYC), .LOCK_TOL(4), .UNLOCK_TOL(12), .LOCK_CNT(3),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut0 (
    .clk_60m(clk_60m), .rst_n(rst_n), .enable(enable),
    .meas_strobe(meas_strobe), .meas_phase(meas_phase),
    .phase_offset(po0), .offset_update(ou0), .mean_err(me0),
    .locked(lk0), .lost(ls0), .state(st0)
  );

  phase_track_ctrl #(
    .TARGET_DEG(10), .AVG_LOG2(AVG_LOG2), .GAIN_SHIFT(GAIN_SHIFT),
    .SETTLE_CYC(SETTLE_CYC), .LOCK_TOL(4), .UNLOCK_TOL(12), .LOCK_CNT(3),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut1 (
    .clk_60m(clk_60m), .rst_n(rst_n), .enable(enable),
    .meas_strobe(meas_strobe), .meas_phase(meas_phase),
    .phase_offset(po1), .offset_update(ou1), .mean_err(me1),
    .locked(lk1), .lost(ls1), .state(st1)
  );

  typedef struct {
    int cyc;
    int m0, o0, u0, l0;
    int m1, o1, u1, l1;
  } exp_t;

  exp_t sb[$];
  exp_t r;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int stray = 0;
  logic prev_adj = 1'b0;

  int tgt_deg[2] = '{90, 10};
  int m_off[2];
  int m_run[2];
  int m_lk[2];

  always @(posedge clk_60m) cyc <= cyc + 1;

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int wrap_ref(input int ph, input int tgt);
    int p;
    p = (ph == 360) ? 0 : ph;
    return ((((p - tgt) % 360) + 360 + 180) % 360) - 180;
  endfunction

  function automatic int floor_div(input int a, input int d);
    int rem;
    rem = a % d;
    if (rem < 0) rem += d;
    return (a - rem) / d;
  endfunction

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      m_off[d] = 0;
      m_run[d] = 0;
      m_lk[d]  = 0;
    end
  endtask

  task automatic m_unlock();
    for (int d = 0; d < 2; d++) begin
      m_run[d] = 0;
      m_lk[d]  = 0;
    end
  endtask

  // Monitor: outputs become visible the cycle after ADJUST.
  always @(negedge clk_60m) begin
    if (prev_adj) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        r = sb.pop_front();
        chk("latency", cyc, r.cyc);
        chk("mean0", me0, r.m0);
        chk("off0", po0, r.o0);
        chk("upd0", ou0, r.u0);
        chk("lock0", lk0, r.l0);
        chk("mean1", me1, r.m1);
        chk("off1", po1, r.o1);
        chk("upd1", ou1, r.u1);
        chk("lock1", lk1, r.l1);
      end
    end else if (ou0 || ou1) begin
      stray++;
    end
    prev_adj = (st0 == 3'd2);
  end

  task automatic send(input int ph, input int gap);
    meas_strobe = 1'b1;
    meas_phase  = 9'(ph);
    @(negedge clk_60m);
    meas_strobe = 1'b0;
    repeat (gap) @(negedge clk_60m);
  endtask

  task automatic wait_state(input int s, input int budget);
    int n;
    n = 0;
    while ((st0 != 3'(s)) && (n < budget)) begin
      @(negedge clk_60m);
      n++;
    end
    chk("wait_state", st0, s);
  endtask

  task automatic run_window(input int p0, input int p1, input int p2, input int p3,
                            input int tail);
    int ph[4];
    int s, mean, corr, a, x;
    int mm[2], oo[2], uu[2];
    exp_t e;
    ph[0] = p0; ph[1] = p1; ph[2] = p2; ph[3] = p3;
    wait_state(1, 100);
    for (int d = 0; d < 2; d++) begin
      s = 0;
      for (int i = 0; i < 4; i++) s += wrap_ref(ph[i], tgt_deg[d]);
      mean = floor_div(s, 1 << AVG_LOG2);
      corr = floor_div(mean * 182, 1 << GAIN_SHIFT);
      x = m_off[d] - corr;
      m_off[d] = ((x % 65536) + 65536) % 65536;
      a = (mean < 0) ? -mean : mean;
      if (a <= 4) begin
        if (m_run[d] < 3) m_run[d]++;
        if (m_run[d] == 3) m_lk[d] = 1;
      end else begin
        m_run[d] = 0;
        if ((m_lk[d] != 0) && (a > 12)) m_lk[d] = 0;
      end
      mm[d] = mean;
      oo[d] = m_off[d];
      uu[d] = (corr != 0) ? 1 : 0;
    end
    for (int i = 0; i < 3; i++) send(ph[i], 1);
    e.cyc = cyc + 2;
    e.m0 = mm[0]; e.o0 = oo[0]; e.u0 = uu[0]; e.l0 = m_lk[0];
    e.m1 = mm[1]; e.o1 = oo[1]; e.u1 = uu[1]; e.l1 = m_lk[1];
    sb.push_back(e);
    send(ph[3], tail);
  endtask

  task automatic out_wait();
    repeat (2) @(negedge clk_60m);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_off0"}, po0, 0);
    chk({pfx, "_upd0"}, ou0, 0);
    chk({pfx, "_mean0"}, me0, 0);
    chk({pfx, "_lock0"}, lk0, 0);
    chk({pfx, "_lost0"}, ls0, 0);
    chk({pfx, "_state0"}, st0, 0);
    chk({pfx, "_off1"}, po1, 0);
    chk({pfx, "_state1"}, st1, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, want finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    m_reset();
    repeat (3) @(negedge clk_60m);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk_60m);
    chk("idle_hold", st0, 0);
    enable = 1'b1;

    // Correction step and wrap-around headline values.
    run_window(100, 100, 100, 100, 1);
    out_wait();
    chk("step_off0", po0, 64626);
    chk("step_mean0", me0, 10);
    run_window(350, 350, 350, 350, 1);
    out_wait();
    chk("wrap_mean1", me1, -20);
    chk("wrap_off1", po1, 59166);
    run_window(360, 360, 360, 360, 1);
    run_window(0, 0, 0, 0, 1);

    // Lock acquire, hold in the hysteresis band, release, floor rounding.
    run_window(90, 90, 90, 90, 1);
    run_window(90, 90, 90, 90, 1);
    out_wait();
    chk("lock_early", lk0, 0);
    run_window(90, 90, 90, 90, 1);
    out_wait();
    chk("lock_rise", lk0, 1);
    run_window(98, 98, 98, 98, 1);
    run_window(110, 110, 110, 110, 1);
    run_window(89, 89, 89, 90, 1);

    // Strobes during ADJUST and SETTLE must not reach the next window.
    run_window(100, 100, 100, 100, 0);
    send(200, 0);
    send(200, 2);
    send(200, 2);
    send(200, 2);
    run_window(90, 90, 90, 90, 1);
    out_wait();
    chk("blank_mean0", me0, 0);

    // Enable drop mid-window.
    wait_state(1, 100);
    send(200, 1);
    send(200, 1);
    enable = 1'b0;
    @(negedge clk_60m);
    chk("dis_state", st0, 0);
    chk("dis_lock", lk0, 0);
    m_unlock();
    @(negedge clk_60m);

    // Loss-of-signal timeout from a fresh start.
    enable = 1'b1;
    @(negedge clk_60m);
    chk("to_start", st0, 1);
    repeat (TIMEOUT_CYC - 1) @(negedge clk_60m);
    chk("to_pre", st0, 1);
    @(negedge clk_60m);
    chk("to_state", st0, 4);
    chk("to_lost0", ls0, 1);
    chk("to_lost1", ls1, 1);
    chk("to_lock", lk0, 0);
    chk("to_off0", po0, m_off[0]);
    chk("to_off1", po1, m_off[1]);
    m_unlock();
    send(300, 0);
    chk("lost_exit_state", st0, 1);
    chk("lost_exit_lost", ls0, 0);
    run_window(100, 100, 100, 100, 1);
    out_wait();
    chk("fresh_mean0", me0, 10);

    // Reset pulse during SETTLE.
    wait_state(3, 50);
    @(negedge clk_60m);
    rst_n = 1'b0;
    @(negedge clk_60m);
    chk_reset_vals("midrst");
    m_reset();
    rst_n = 1'b1;
    run_window(100, 100, 100, 100, 1);
    out_wait();
    chk("post_rst_off0", po0, 64626);

    repeat (4) @(negedge clk_60m);
    chk("sb_left", sb.size(), 0);
    chk("stray_upd", stray, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
